// File: rtl/intr_responder.sv
// CPU-side interrupt responder: takes prioritised requests, stacks EPC/level, returns on ERET.
// Define INTR_NESTED_EN for nested preemption up to DEPTH levels; otherwise single-level service.
module intr_responder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IntR,
  input  logic [1:0]       IntNo,
  input  logic [WIDTH-1:0] IntAddr,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             eret,
  input  logic             halt,
  output logic             redirect_en,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [2:0]       ack,
  output logic [1:0]       cur_level,
  output logic             ie
);

`ifdef INTR_NESTED_EN
  localparam bit NESTED = 1'b1;
`else
  localparam bit NESTED = 1'b0;
`endif

  localparam int unsigned EFF_DEPTH = NESTED ? ((DEPTH == 0) ? 1 : DEPTH) : 1;
  localparam int unsigned SP_W      = $clog2(EFF_DEPTH + 1);
  localparam int unsigned IDX_W     = (EFF_DEPTH > 1) ? $clog2(EFF_DEPTH) : 1;

  logic [1:0]       r_cur_level;
  logic [SP_W-1:0]  r_sp;
  logic [WIDTH-1:0] r_stk_epc [EFF_DEPTH];
  logic [1:0]       r_stk_lvl [EFF_DEPTH];

  logic             w_ie;
  logic             w_take;
  logic             w_ret;
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_pop_idx;
  logic [SP_W-1:0]  w_sp_nxt;
  logic [1:0]       w_lvl_nxt;

  // Take/return decision, same-cycle redirect and ack, and next stack state
  always_comb begin
    w_ie        = 1'b0;
    w_take      = 1'b0;
    w_ret       = 1'b0;
    w_push_idx  = '0;
    w_pop_idx   = '0;
    w_sp_nxt    = r_sp;
    w_lvl_nxt   = r_cur_level;
    redirect_en = 1'b0;
    redirect_pc = '0;
    ack         = 3'b000;

    w_ie       = (r_sp < SP_W'(EFF_DEPTH));
    w_push_idx = IDX_W'(r_sp);
    if (r_sp != '0) begin
      w_pop_idx = IDX_W'(r_sp - SP_W'(1));
    end

    // ERET has priority: a colliding request stays pending at its source
    w_ret  = ~rst & eret & (r_sp != '0);
    w_take = ~rst & IntR & (IntNo > r_cur_level) & w_ie & ~halt & ~eret
             & (NESTED | (r_cur_level == 2'd0));

    if (w_take) begin
      redirect_en              = 1'b1;
      redirect_pc              = IntAddr;
      ack[IntNo - 2'd1]        = 1'b1;
      w_sp_nxt                 = r_sp + SP_W'(1);
      w_lvl_nxt                = IntNo;
    end else if (w_ret) begin
      redirect_en              = 1'b1;
      redirect_pc              = r_stk_epc[w_pop_idx];
      w_sp_nxt                 = r_sp - SP_W'(1);
      w_lvl_nxt                = r_stk_lvl[w_pop_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp        <= '0;
      r_cur_level <= 2'd0;
    end else begin
      r_sp        <= w_sp_nxt;
      r_cur_level <= w_lvl_nxt;
    end
  end

  // Stack contents need no reset: sp=0 makes every entry unreachable
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_stk_epc[w_push_idx] <= pc_next;
      r_stk_lvl[w_push_idx] <= r_cur_level;
    end
  end

  assign cur_level = r_cur_level;
  assign ie        = w_ie;

endmodule

// File: tb/tb_intr_responder.sv
// Directed bench for intr_responder with a queue-based reference model checked every cycle.
module tb_intr_responder;

`ifdef INTR_NESTED_EN
  localparam bit NESTED = 1'b1;
`else
  localparam bit NESTED = 1'b0;
`endif
  localparam int CAP = NESTED ? 3 : 1;

  logic        clk = 1'b0;
  logic        rst, IntR, eret, halt;
  logic [1:0]  IntNo;
  logic [31:0] IntAddr, pc_next;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [2:0]  ack;
  logic [1:0]  cur_level;
  logic        ie;

  int n_tests = 0;
  int n_fail  = 0;

  intr_responder #(.WIDTH(32), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .IntR(IntR), .IntNo(IntNo), .IntAddr(IntAddr),
    .pc_next(pc_next), .eret(eret), .halt(halt), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .ack(ack), .cur_level(cur_level), .ie(ie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: service stack as queues, compared on every falling edge
  int          m_lvl   = 0;
  bit          m_valid = 1'b0;
  logic [31:0] q_epc[$];
  int          q_lvl[$];

  always begin
    bit          take, ret;
    logic        e_en;
    logic [31:0] e_pc;
    logic [2:0]  e_ack;
    @(negedge clk);
    take  = 1'b0;
    ret   = 1'b0;
    e_en  = 1'b0;
    e_pc  = 32'h0;
    e_ack = 3'b000;
    if (!rst && m_valid) begin
      ret  = eret && (q_epc.size() != 0);
      take = IntR && (int'(IntNo) > m_lvl) && (q_epc.size() < CAP) && !halt && !eret
             && (NESTED || m_lvl == 0);
      if (take) begin
        e_en  = 1'b1;
        e_pc  = IntAddr;
        e_ack = 3'(1 << (int'(IntNo) - 1));
      end else if (ret) begin
        e_en  = 1'b1;
        e_pc  = q_epc[q_epc.size() - 1];
      end
    end
    if (rst || m_valid) begin
      chk("model.redirect_en", 32'(redirect_en), 32'(e_en));
      chk("model.redirect_pc", redirect_pc, e_pc);
      chk("model.ack", 32'(ack), 32'(e_ack));
    end
    if (m_valid) begin
      chk("model.cur_level", 32'(cur_level), 32'(m_lvl));
      chk("model.ie", 32'(ie), 32'(q_epc.size() < CAP));
    end
    if (rst) begin
      m_lvl = 0;
      q_epc.delete();
      q_lvl.delete();
      m_valid = 1'b1;
    end else if (take) begin
      q_epc.push_back(pc_next);
      q_lvl.push_back(m_lvl);
      m_lvl = int'(IntNo);
    end else if (ret) begin
      m_lvl = q_lvl[q_lvl.size() - 1];
      void'(q_epc.pop_back());
      void'(q_lvl.pop_back());
    end
  end

  // One cycle of stimulus; outputs are settled when the task returns
  task automatic cyc(input logic r, input logic ir, input logic [1:0] no,
                     input logic [31:0] addr, input logic [31:0] pcn,
                     input logic er, input logic hl);
    @(posedge clk);
    #1;
    rst = r; IntR = ir; IntNo = no; IntAddr = addr; pc_next = pcn; eret = er; halt = hl;
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_eret();
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic take(input logic [1:0] no, input logic [31:0] addr, input logic [31:0] pcn);
    cyc(1'b0, 1'b1, no, addr, pcn, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; IntR = 1'b0; IntNo = 2'd0; IntAddr = '0; pc_next = '0; eret = 1'b0; halt = 1'b0;

    // Reset gates outputs even with a request present
    cyc(1'b1, 1'b1, 2'd3, 32'h100, 32'h200, 1'b0, 1'b0);
    chk("rst.redirect_en", 32'(redirect_en), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    cyc(1'b1, 1'b1, 2'd3, 32'h100, 32'h200, 1'b0, 1'b0);
    chk("rst.redirect_pc", redirect_pc, 32'h0);
    idle();
    chk("post_rst.redirect_en", 32'(redirect_en), 32'd0);
    chk("post_rst.ack", 32'(ack), 32'd0);
    chk("post_rst.cur_level", 32'(cur_level), 32'd0);
    chk("post_rst.ie", 32'(ie), 32'd1);

    // Single take
    take(2'd1, 32'h3498, 32'h3010);
    chk("take1.redirect_en", 32'(redirect_en), 32'd1);
    chk("take1.redirect_pc", redirect_pc, 32'h3498);
    chk("take1.ack", 32'(ack), 32'b001);
    idle();
    chk("take1.cur_level", 32'(cur_level), 32'd1);
    chk("take1.ie", 32'(ie), NESTED ? 32'd1 : 32'd0);

    if (NESTED) begin
      take(2'd3, 32'h35f0, 32'h34a0);
      chk("nest.redirect_pc", redirect_pc, 32'h35f0);
      chk("nest.ack", 32'(ack), 32'b100);
      idle();
      chk("nest.cur_level", 32'(cur_level), 32'd3);
      do_eret();
      chk("nest.eret1_pc", redirect_pc, 32'h34a0);
      idle();
      chk("nest.eret1_level", 32'(cur_level), 32'd1);
      do_eret();
      chk("nest.eret2_pc", redirect_pc, 32'h3010);
      idle();
      chk("nest.eret2_level", 32'(cur_level), 32'd0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        take(2'd3, 32'h35f0, 32'h34a0);
        chk("single.no_preempt_en", 32'(redirect_en), 32'd0);
        chk("single.no_preempt_ack", 32'(ack), 32'd0);
      end
      cyc(1'b0, 1'b1, 2'd3, 32'h35f0, 32'h34a0, 1'b1, 1'b0);
      chk("single.eret_pc", redirect_pc, 32'h3010);
      chk("single.eret_ack", 32'(ack), 32'd0);
      take(2'd3, 32'h35f0, 32'h34a0);
      chk("single.pending_take_ack", 32'(ack), 32'b100);
      do_eret();
      chk("single.eret2_pc", redirect_pc, 32'h34a0);
      idle();
      chk("single.level0", 32'(cur_level), 32'd0);
    end

    // ERET colliding with a request: return first, then back-to-back take
    take(2'd1, 32'h1000, 32'h2000);
    cyc(1'b0, 1'b1, 2'd3, 32'h1300, 32'h2100, 1'b1, 1'b0);
    chk("coll.redirect_pc", redirect_pc, 32'h2000);
    chk("coll.ack", 32'(ack), 32'd0);
    take(2'd3, 32'h1300, 32'h2104);
    chk("coll.level_restored", 32'(cur_level), 32'd0);
    chk("coll.take_ack", 32'(ack), 32'b100);
    chk("coll.take_pc", redirect_pc, 32'h1300);
    do_eret();
    chk("coll.ret_pc", redirect_pc, 32'h2104);

    // Equal/lower priority blocked during a level-2 handler
    take(2'd2, 32'h4000, 32'h5000);
    for (int i = 0; i < 10; i++) begin
      take((i < 5) ? 2'd1 : 2'd2, 32'h4100, 32'h5100);
      chk("block.redirect_en", 32'(redirect_en), 32'd0);
      chk("block.ack", 32'(ack), 32'd0);
    end
    cyc(1'b0, 1'b1, 2'd1, 32'h4100, 32'h5100, 1'b1, 1'b0);
    chk("block.eret_pc", redirect_pc, 32'h5000);
    take(2'd1, 32'h4100, 32'h5100);
    chk("block.late_take_ack", 32'(ack), 32'b001);
    do_eret();
    chk("block.ret_pc", redirect_pc, 32'h5100);

    // ERET with empty stack is ignored
    do_eret();
    chk("eret0.redirect_en", 32'(redirect_en), 32'd0);
    chk("eret0.redirect_pc", redirect_pc, 32'h0);
    idle();
    chk("eret0.cur_level", 32'(cur_level), 32'd0);
    chk("eret0.ie", 32'(ie), 32'd1);

    // halt blocks takes but not returns; malformed IntNo=0 never taken
    cyc(1'b0, 1'b1, 2'd3, 32'h35f0, 32'h1, 1'b0, 1'b1);
    chk("halt.redirect_en", 32'(redirect_en), 32'd0);
    chk("halt.ack", 32'(ack), 32'd0);
    take(2'd2, 32'h6000, 32'h7000);
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("halt.ret_pc", redirect_pc, 32'h7000);
    take(2'd0, 32'h8000, 32'h9000);
    chk("intno0.redirect_en", 32'(redirect_en), 32'd0);

    if (NESTED) begin
      take(2'd1, 32'ha000, 32'hb000);
      take(2'd2, 32'ha100, 32'hb100);
      take(2'd3, 32'ha200, 32'hb200);
      idle();
      chk("full.ie", 32'(ie), 32'd0);
      for (int i = 0; i < 3; i++) do_eret();
      idle();
      chk("full.drained_ie", 32'(ie), 32'd1);
    end

    // Reset mid-handler discards the stack
    take(2'd2, 32'hc000, 32'hd000);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_eret();
    chk("rst_mid.redirect_en", 32'(redirect_en), 32'd0);
    chk("rst_mid.cur_level", 32'(cur_level), 32'd0);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_responder.md
Name: intr_responder

Overview:
- CPU-side consumer of the prioritised interrupt request bundle (IntR, IntNo, IntAddr) produced by the interrupt priority encoder.
- Decides when a request is taken and saves the return PC (EPC) with the interrupted priority level on a small stack.
- Redirects the PC to the service address, returns on ERET, and pulses a per-source acknowledge that clears the requesting source latch.
- Supports multi-level (nested) service: only a strictly higher priority preempts a running handler.

Parameters:
- WIDTH, 32, width of PC, IntAddr and EPC.
- DEPTH, 3, EPC/level stack entries (max nesting depth).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- IntR  input  1  any request pending (from encoder).
- IntNo  input  2  highest pending priority, 1..3; 0 = none.
- IntAddr  input  WIDTH  service routine entry for IntNo.
- pc_next  input  WIDTH  address of the next instruction if not redirected; saved as EPC.
- eret  input  1  ERET executing this cycle.
- halt  input  1  CPU halted; no interrupt is taken.
- redirect_en  output  1  PC must load redirect_pc this cycle.
- redirect_pc  output  WIDTH  IntAddr on take, popped EPC on return.
- ack  output  3  one-hot source clear; bit IntNo-1 pulses on take.
- cur_level  output  2  priority currently in service, 0 = main program.
- ie  output  1  interrupts enabled (stack not full).

Behaviour:
- Registered state:
  - cur_level (2b).
  - sp (stack pointer, 0..DEPTH).
  - stack of DEPTH entries {epc[WIDTH], lvl[2]}.
  - ie = (sp < DEPTH), derived from sp.
- Reset (rst=1 at a clk edge): cur_level=0, sp=0, stack contents don't-care.
  - While rst=1, redirect_en=0, ack=0, redirect_pc=0.
  - After reset: cur_level=0, ie=1.
- take = IntR & (IntNo > cur_level) & ie & ~halt & ~eret. Combinational, same cycle as request.
- On take:
  - redirect_en=1, redirect_pc=IntAddr, ack[IntNo-1]=1. All combinational.
  - At the edge: stack[sp] <= {pc_next, cur_level}; sp <= sp+1; cur_level <= IntNo.
- ret = eret & (sp != 0). Combinational.
- On ret:
  - redirect_en=1, redirect_pc=stack[sp-1].epc.
  - At the edge: sp <= sp-1; cur_level <= stack[sp-1].lvl. ack=0.
- ERET with sp=0: ignored. No redirect, state unchanged.
- Simultaneous eret and IntR: eret wins. The request is not taken or acked and stays pending at the source. It is re-evaluated the next cycle against the restored cur_level, giving back-to-back service.
- IntNo <= cur_level: not taken, no ack. The request stays pending until the level drops.
- Stack full (sp=DEPTH, ie=0): no take regardless of IntNo.
- Idle (neither take nor ret): redirect_en=0, redirect_pc=0, ack=0, state held.
- IntNo=0 with IntR=1 (malformed): never taken, because 0 is not > cur_level.
- halt=1: take is blocked; ret is still honoured.
- Reset mid-handler: stack discarded, cur_level=0. No ret is possible afterwards.
- Latency: redirect and ack are in the same cycle as the request or ERET. The new level applies from the next cycle.

Optional Feature:
- Macro: INTR_NESTED_EN.
- Defined: nesting exactly as above, up to DEPTH levels, with preemption by strictly higher IntNo.
- Undefined: single-level service.
  - take additionally requires cur_level==0.
  - The stack collapses to one entry (DEPTH is ignored, effective depth 1).
  - ie = (sp==0).
  - A higher-priority request arriving during a handler stays pending until ERET.

Test Plan:
- Reset: rst=1 for 2 cycles, then IntR=0 -> redirect_en=0, ack=000, cur_level=0, ie=1.
- Single take: cur_level=0, IntR=1, IntNo=1, IntAddr=0x3498, pc_next=0x3010 -> same cycle redirect_en=1, redirect_pc=0x3498, ack=001; next cycle cur_level=1. Later eret=1 -> redirect_pc=0x3010, cur_level=0.
- Nesting (INTR_NESTED_EN): in level-1 handler, IntNo=3, IntAddr=0x35f0, pc_next=0x34a0 -> take, ack=100, cur_level=3. ERET -> redirect_pc=0x34a0, cur_level=1. ERET -> original EPC, cur_level=0.
- Blocking: in level-2 handler, IntNo=1 or IntNo=2 held -> no redirect, ack=000 for 10 cycles. After ERET to level 0, IntNo=1 is taken the next cycle.
- Eret collision: eret=1 with IntR=1, IntNo=3 -> redirect_pc=EPC, ack=000. The following cycle IntNo=3 is taken with ack=100.
- Boundaries: ERET with sp=0 -> redirect_en=0, no state change. halt=1 with IntNo=3 -> no take. Without INTR_NESTED_EN, IntNo=3 during a level-1 handler -> no take until ERET.
